// File: rtl/muldiv_ctrl_if.sv
// Execute-stage M-extension interface: decoder/ALU inputs on one side,
// write-back result and pipeline stall on the other.
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            md_req;
  logic [2:0]      md_op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_out;
  logic            flush;
  logic [XLEN-1:0] exec_result;
  logic            stall;
  logic            md_busy;

  modport master (
    output md_req, md_op, rs1_data, rs2_data, alu_out, flush,
    input  exec_result, stall, md_busy
  );

  modport slave (
    input  md_req, md_op, rs1_data, rs2_data, alu_out, flush,
    output exec_result, stall, md_busy
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: ALU passthrough, or an iterative shift-add multiply /
// restoring divide that stalls the pipeline and presents its result for one cycle.
module muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  md_if
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;       // product high / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier / dividend -> quotient
  logic            sa_q, sa_d, sb_q, sb_d;

  logic            a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, md_result;

  always_comb begin
    a_signed = (md_if.md_op == 3'd1) || (md_if.md_op == 3'd2) ||
               (md_if.md_op == 3'd4) || (md_if.md_op == 3'd6);
    b_signed = (md_if.md_op == 3'd1) || (md_if.md_op == 3'd4) || (md_if.md_op == 3'd6);
    neg_a    = a_signed & md_if.rs1_data[XLEN-1];
    neg_b    = b_signed & md_if.rs2_data[XLEN-1];
    mag_a    = neg_a ? -md_if.rs1_data : md_if.rs1_data;
    mag_b    = neg_b ? -md_if.rs2_data : md_if.rs2_data;
    div_zero = md_if.md_op[2] && (md_if.rs2_data == '0);
    div_ovf  = md_if.md_op[2] && !md_if.md_op[0] &&
               (md_if.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (md_if.rs2_data == '1);
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    if (md_if.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (md_if.md_req) begin
          op_d  = md_if.md_op;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            // Preload quotient/remainder with clean signs so DONE needs no fix-up.
            state_d = S_DONE;
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            opnd_d  = '0;
            lo_d    = div_zero ? '1 : md_if.rs1_data;
            hi_d    = div_zero ? md_if.rs1_data : '0;
          end else begin
            state_d = S_BUSY;
            sa_d    = neg_a;
            sb_d    = neg_b;
            opnd_d  = md_if.md_op[2] ? mag_b : mag_a;
            lo_d    = md_if.md_op[2] ? mag_a : mag_b;
            hi_d    = '0;
          end
        end
        S_BUSY: begin
          if (op_q[2]) begin
            hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    quo_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem_fix  = sa_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:                md_result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    md_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          md_result = quo_fix;
      default:             md_result = rem_fix;
    endcase
  end

  assign md_if.exec_result = (state_q == S_DONE) ? md_result : md_if.alu_out;
  assign md_if.stall       = !md_if.flush &&
                             (((state_q == S_IDLE) && md_if.md_req) || (state_q == S_BUSY));
  assign md_if.md_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against an arithmetic RV32M reference model.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .md_if (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, pu, p;
    logic signed [31:0] sa, sb;
    pa = $signed({{32{a[31]}}, a});
    pb = $signed({{32{b[31]}}, b});
    pu = $signed({32'b0, b});
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: begin p = pa * pb; return p[31:0]; end
      3'd1: begin p = pa * pb; return p[63:32]; end
      3'd2: begin p = pa * pu; return p[63:32]; end
      3'd3: begin p = $signed({32'b0, a}) * pu; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return sa / sb;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one M-op, hold md_req through the stall (and DONE), scramble operands while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          stalls;
    int          want;
    exp  = ref_md(op, a, b);
    want = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    @(negedge clk);
    bus.md_req   = 1'b1;
    bus.md_op    = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.alu_out  = $urandom;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.stall) break;
      stalls++;
      @(negedge clk);
      bus.rs1_data = $urandom;
      bus.rs2_data = $urandom;
    end
    chk("stall_len", 32'(stalls), 32'(want));
    chk("result", bus.exec_result, exp);
    chk("done_busy", {31'b0, bus.md_busy}, 32'd1);
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h expected=0x%08h stalls=%0d",
             op, a, b, bus.exec_result, exp, stalls);
    @(negedge clk);
    bus.md_req  = 1'b0;
    bus.alu_out = $urandom;
    #1;
    chk("after_idle", {31'b0, bus.md_busy}, 32'd0);
    chk("after_pass", bus.exec_result, bus.alu_out);
  endtask

  // Abort a DIV in its 10th BUSY cycle by flush or reset, then prove recovery.
  task automatic abort_test(input bit use_rst);
    @(negedge clk);
    bus.md_req   = 1'b1;
    bus.md_op    = 3'd4;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd3;
    #1 chk("abort_accept", {31'b0, bus.stall}, 32'd1);
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         bus.flush = 1'b1;
    #1;
    if (!use_rst) chk("flush_stall", {31'b0, bus.stall}, 32'd0);
    chk("abort_busy_pre", {31'b0, bus.md_busy}, 32'd1);
    @(negedge clk);
    rst        = 1'b0;
    bus.flush  = 1'b0;
    bus.md_req = 1'b0;
    #1;
    chk("abort_busy_post", {31'b0, bus.md_busy}, 32'd0);
    chk("abort_stall_post", {31'b0, bus.stall}, 32'd0);
    $display("abort via %s, then MUL 3x4", use_rst ? "rst" : "flush");
    run_op(3'd0, 32'd3, 32'd4);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.md_req   = 1'b0;
    bus.md_op    = 3'd0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.alu_out  = '0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_busy", {31'b0, bus.md_busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.alu_out = (i == 0) ? 32'h1234_5678 : $urandom;
      #1;
      chk("alu_pass", bus.exec_result, (i == 0) ? 32'h1234_5678 : bus.alu_out);
      chk("alu_stall", {30'b0, bus.stall, bus.md_busy}, 32'd0);
      $display("alu passthrough alu_out=0x%08h result=0x%08h", bus.alu_out, bus.exec_result);
    end

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd100, 32'd0);
    run_op(3'd6, 32'd100, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    abort_test(1'b0);
    abort_test(1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20)) * (($urandom & 1) != 0 ? 32'hFFFF_FFFF : 32'd1);
        default: ;
      endcase
      run_op(op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the RV32M extension; shares the execute-stage result port between the single-cycle ALU and an iterative multiply/divide engine.
- Plain ALU ops pass `alu_out` straight through.
- M-ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) start a multi-cycle FSM. The block holds `stall` to freeze fetch/decode, then presents the result to write back for exactly one cycle.
- Sits between execute (ALU output) and write back; controlled by decoder outputs.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- md_req  in  1  decoder: current instruction is an M-op
- md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  in  XLEN  operand A from regfile
- rs2_data  in  XLEN  operand B from regfile
- alu_out  in  XLEN  ALU result
- flush  in  1  kill the in-flight M-op (branch/trap)
- exec_result  out  XLEN  result to write back
- stall  out  1  freeze pipeline (PC, decode regs)
- md_busy  out  1  FSM not IDLE (debug/perf)

Behaviour:
- Reset (synchronous, active-high): state = IDLE, counter = 0, all internal registers = 0, `stall` = 0, `md_busy` = 0. `exec_result` then follows `alu_out`.
- States: IDLE, BUSY, DONE.

IDLE:
- If `md_req` = 0: `exec_result` = `alu_out`, `stall` = 0.
- If `md_req` = 1: `stall` = 1 (combinational). On the clock edge, latch operand magnitudes, sign flags and `md_op`, and set counter = 0.
- Special divide cases go directly to DONE with a precomputed result:
  - Divide by zero: quotient = all ones (DIV/DIVU); remainder = dividend (REM/REMU).
  - Signed overflow (0x80000000 / -1): DIV = 0x80000000, REM = 0.
- Otherwise go to BUSY.

BUSY:
- `stall` = 1. One iteration per cycle, XLEN iterations; counter increments each cycle. When counter = XLEN-1, go to DONE.
- Multiply: shift-add on unsigned magnitudes into a 2·XLEN accumulator.
  - Signedness: MULH = s×s, MULHSU = s×u, MULHU = u×u, MUL = low word (signedness irrelevant).
- Divide: restoring, unsigned magnitudes, one quotient bit per cycle.
- Final sign fix is applied in the DONE cycle (combinational from the latched flags):
  - Product is negated if the operand signs differ for the signed variants.
  - Quotient is negated if signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Result selection: MUL = product[XLEN-1:0]; MULH* = product[2XLEN-1:XLEN]; DIV* = quotient; REM* = remainder.

DONE:
- `stall` = 0 and `exec_result` = final M result for exactly one cycle; the pipeline advances on this edge.
- Next state is always IDLE; `md_req` is ignored in this cycle, which prevents re-issue.

Latency:
- Normal M-op: accept cycle + XLEN BUSY cycles + 1 DONE cycle. `stall` is high for XLEN+1 = 33 consecutive cycles; the result appears in cycle 33 relative to accept (cycle 0).
- Special divide case: `stall` is high for 1 cycle; result in cycle 1.

Other rules:
- `md_busy` = (state != IDLE).
- `flush` in any state: next state = IDLE and counter = 0. `stall` is forced to 0 combinationally that cycle. `flush` has priority over all transitions; an M-op flushed in IDLE is not accepted.
- Reset has priority over `flush`.
- Operands are latched at accept; changes on `rs1_data`/`rs2_data` during BUSY have no effect.

Test Plan:
- ALU passthrough: `md_req` = 0, `alu_out` = 0x12345678 → `exec_result` = 0x12345678 in the same cycle; `stall` = 0 and `md_busy` = 0 throughout.
- MUL 7 × 0xFFFFFFFD (-3):
  - `stall` high 33 cycles.
  - DONE cycle: `exec_result` = 0xFFFFFFEB, `stall` = 0.
  - Next cycle: IDLE.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD.
- REM of the same operands → 0xFFFFFFFF.
- DIVU 100 / 7 → 14.
- REMU 100 / 7 → 2.
- Special divide cases:
  - DIVU 100 / 0 → 0xFFFFFFFF.
  - REM 100 / 0 → 100.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
  - Each: `stall` exactly 1 cycle, result in the following cycle.
- Flush/reset mid-op:
  - Start DIV; assert `flush` in BUSY cycle 10 → `stall` = 0 that cycle and state = IDLE the next. A following MUL 3 × 4 → 12 after a full 33-cycle stall.
  - Repeat with `rst` at cycle 10 → same recovery, and `md_busy` = 0 after the edge.
